slow_clk_monitor: RTL

Receiving end of the divided slow clock (the ~4 ms scan/tick clock produced by the clock divider). Synchronizes the slow clock into the `clk` domain and turns its edges into single-cycle strobes. Measures each rise-to-rise period in `clk` cycles and checks it against a window. Reports lock, per-period errors and loss of the slow clock, so downstream logic can use clean enables instead of clocking on the divided clock directly.

---
 rtl/slow_clk_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: receives the divided scan/tick clock, synchronizes it into
// the clk domain, emits single-cycle edge strobes and measures every
// rise-to-rise period against a [MIN_PERIOD, MAX_PERIOD] window. Reports lock,
// per-period range errors and loss of the slow clock so downstream logic can
// run from clean enables instead of clocking on the divided clock.
module slow_clk_monitor #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 399_000,
  parameter int MAX_PERIOD = 401_000,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             too_short,
  output logic             too_long,
  output logic             lost,
  output logic             locked,
  output logic             err_sticky
);

  // good_cnt must be able to hold LOCK_COUNT itself (it saturates there).
  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_P   = CNT_W'(MAX_PERIOD);
  localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] LOCK_M1 = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t            state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              rise_det;
  logic              fall_det;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [CNT_W-1:0]  p_meas;
  logic              p_short;
  logic              p_long;
  logic              p_in_range;
  logic              err_event;

  // Edges are taken between the second sync stage and the history flop, so
  // the FSM reacts on the same edge that registers rise_pulse.
  assign rise_det = s2 & ~s3;
  assign fall_det = ~s2 & s3;

  // The rise cycle itself is part of the period, hence the +1.
  assign p_meas     = cnt + CNT_W'(1);
  assign p_short    = (p_meas < MIN_P);
  assign p_long     = (p_meas > MAX_P);
  assign p_in_range = ~p_short & ~p_long;

  assign locked    = (state == ST_LOCKED);
  assign err_event = too_short | too_long | lost;

  // Two-flop synchronizer for the asynchronous slow clock plus a history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Registered single-cycle edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
    end
  end

  // Period measurement, range check, lock tracking and loss timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_WAIT;
      cnt          <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;
      lost         <= 1'b0;
      case (state)
        ST_WAIT: begin
          // First edge only starts a measurement; there is no period yet.
          cnt <= '0;
          if (rise_det) begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (rise_det) begin
            // A rise always wins over the timeout, so a MAX_PERIOD+1 period
            // reports too_long rather than lost.
            period       <= p_meas;
            period_valid <= 1'b1;
            cnt          <= '0;
            if (p_in_range) begin
              if (good_cnt < LOCK_C) begin
                good_cnt <= good_cnt + 1'b1;
              end
              if (good_cnt >= LOCK_M1) begin
                state <= ST_LOCKED;
              end
            end else begin
              too_short <= p_short;
              too_long  <= p_long;
              good_cnt  <= '0;
              state     <= ST_MEASURE;
            end
          end else if (cnt == MAX_P) begin
            // Timeout also bounds cnt, so it can never wrap.
            lost     <= 1'b1;
            good_cnt <= '0;
            cnt      <= '0;
            state    <= ST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt      <= '0;
          good_cnt <= '0;
          state    <= ST_WAIT;
        end
      endcase
    end
  end

  // Sticky error flag; a new error in the same cycle as clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err_event) begin
      err_sticky <= 1'b1;
    end else if (clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule
